// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, engine state encodings and the address-decode result.
package axi_lite_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 1024;
    localparam int unsigned DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int unsigned IDX_W          = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_DELAY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

    // idx is sized for the default depth; smaller memories use its low bits.
    typedef struct packed {
        resp_t            resp;
        logic [IDX_W-1:0] idx;
    } dec_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle; master drives requests, slave drives readies and responses.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational byte-address to word-index decode; DECERR outside the window wins over SLVERR for misalignment.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           DEPTH      = DEF_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output dec_t                  dec
);
    localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned           LSB        = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH * STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK   = ADDR_WIDTH'(STRB_WIDTH - 1);

    logic [ADDR_WIDTH-1:0] offset;

    always_comb begin
        offset   = addr - BASE_ADDR;
        dec.idx  = IDX_W'(offset >> LSB);
        dec.resp = RESP_OKAY;
        if ((addr < BASE_ADDR) || ({1'b0, offset} >= SPAN)) begin
            dec.resp = RESP_DECERR;
            dec.idx  = '0;
        end else if ((offset & LSB_MASK) != '0) begin
            dec.resp = RESP_SLVERR;
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave: B at last AW/W handshake +2+RESP_DELAY, R at AR handshake +1+RESP_DELAY.
// Each channel takes one request at a time; BVALID/RVALID hold until BREADY/RREADY.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           DEPTH      = DEF_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           RESP_DELAY = 0
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    axi_lite_if.slave  s
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned MEM_IW     = $clog2(DEPTH);
    localparam logic [3:0]  DLY        = 4'(RESP_DELAY);

    if ((MEM_IW > IDX_W) || (RESP_DELAY > 15)) begin : g_param_check
        $error("axi_lite_mem_slave: DEPTH or RESP_DELAY out of range");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    dec_t                  aw_dec, ar_dec;

    axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR))
        u_aw_dec (.addr(s.AWADDR), .dec(aw_dec));
    axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR))
        u_ar_dec (.addr(s.ARADDR), .dec(ar_dec));

    // ---------------- write engine ----------------
    w_state_t              w_state_q, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    resp_t                 wresp_q, wresp_d, bresp_q, bresp_d;
    logic [MEM_IW-1:0]     widx_q, widx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic                  bvalid_q, bvalid_d;
    logic                  mem_we;

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        wresp_d   = wresp_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wcnt_d    = wcnt_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s.AWVALID && awready_q) begin
                    aw_got_d = 1'b1;
                    wresp_d  = aw_dec.resp;
                    widx_d   = MEM_IW'(aw_dec.idx);
                end
                if (s.WVALID && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = s.WDATA;
                    wstrb_d = s.WSTRB;
                end
                if (aw_got_d && w_got_d) begin
                    w_state_d = W_COMMIT;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                end
            end
            W_COMMIT: begin
                mem_we = (wresp_q == RESP_OKAY);
                if (DLY == 4'd0) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wresp_q;
                end else begin
                    w_state_d = W_DELAY;
                    wcnt_d    = DLY;
                end
            end
            W_DELAY: begin
                if (wcnt_q <= 4'd1) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = wresp_q;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (s.BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // each READY drops after its own handshake and only reopens once the response is taken
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            wresp_q   <= RESP_OKAY;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wcnt_q    <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            wresp_q   <= wresp_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wcnt_q    <= wcnt_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Contents survive reset; a read sampled on the commit edge sees the old word.
    always_ff @(posedge ACLK) begin
        if (ARESETN && mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_q[b]) mem[widx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic [3:0]            rcnt_q, rcnt_d;
    logic                  rvalid_q, rvalid_d;
    resp_t                 rrbuf_q, rrbuf_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d, rdata_q, rdata_d;
    logic [MEM_IW-1:0]     ar_idx;

    assign ar_idx = MEM_IW'(ar_dec.idx);

    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rrbuf_d   = rrbuf_q;
        rbuf_d    = rbuf_q;
        case (r_state_q)
            R_IDLE: begin
                if (s.ARVALID && arready_q) begin
                    rbuf_d  = (ar_dec.resp == RESP_OKAY) ? mem[ar_idx] : '0;
                    rrbuf_d = ar_dec.resp;
                    if (DLY == 4'd0) begin
                        r_state_d = R_RESP;
                        rvalid_d  = 1'b1;
                    end else begin
                        r_state_d = R_DELAY;
                        rcnt_d    = DLY;
                    end
                end
            end
            R_DELAY: begin
                if (rcnt_q <= 4'd1) begin
                    r_state_d = R_RESP;
                    rvalid_d  = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (s.RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        // the response is buffered through the delay so RDATA stays 0 until RVALID rises
        rdata_d   = rvalid_d ? rbuf_d : '0;
        rresp_d   = rvalid_d ? rrbuf_d : RESP_OKAY;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b0;
            rrbuf_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rbuf_q    <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rcnt_q    <= rcnt_d;
            rvalid_q  <= rvalid_d;
            rrbuf_q   <= rrbuf_d;
            rresp_q   <= rresp_d;
            rbuf_q    <= rbuf_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s.AWREADY = awready_q;
    assign s.WREADY  = wready_q;
    assign s.BVALID  = bvalid_q;
    assign s.BRESP   = bresp_q;
    assign s.ARREADY = arready_q;
    assign s.RVALID  = rvalid_q;
    assign s.RRESP   = rresp_q;
    assign s.RDATA   = rdata_q;

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
Parametrised AXI4-Lite memory-mapped slave. It is the next generation of the fixed 8-bit/32-bit bus slave used by the current testbench. It generalises data width, memory depth and base address. It adds byte-strobe writes, DECERR and SLVERR responses, independent read and write engines, and a programmable response delay. It sits behind the interconnect as a terminal slave and is the DUT target for the generator/driver/monitor/scoreboard environment.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; legal values 8/16/32/64
DEPTH, 1024, memory size in DATA_WIDTH words; power of two
BASE_ADDR, 32'h0, byte address of word 0; aligned to DEPTH*STRB_WIDTH
RESP_DELAY, 0, extra idle cycles (0..15) inserted before RVALID/BVALID

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETN  in  1  synchronous active-low reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read response valid
RREADY  in  1  read response ready

Behaviour:
- Reset (ARESETN=0 at a rising edge): all outputs register to 0. Both FSMs go to IDLE and the delay counters clear. Memory contents are not reset. Reset mid-transaction drops any pending response; RVALID/BVALID are 0 the cycle after reset is sampled.
- READY outputs are registered. AWREADY, WREADY and ARREADY go to 1 in the first cycle after reset deasserts.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1. AW and W may handshake in the same cycle or in either order. Each channel's READY drops after its own handshake. The address and data/strb are captured.
  - When both are captured, the FSM goes to W_COMMIT. Memory is updated here; on a decode error memory is not updated.
  - W_COMMIT then goes to W_DELAY, where a counter runs RESP_DELAY cycles. It is skipped when RESP_DELAY=0.
  - W_RESP: BVALID=1 and BRESP is held until BREADY. On the handshake the FSM returns to W_IDLE with both READYs at 1 the next cycle.
  - Latency: last of AW/W handshake at cycle N gives BVALID at N+2+RESP_DELAY.
- Read FSM states:
  - R_IDLE: ARREADY=1. On an AR handshake the address is captured and the memory is read.
  - R_DELAY: counter runs RESP_DELAY cycles.
  - R_RESP: RVALID=1 with RDATA/RRESP held stable until RREADY. On the handshake the FSM returns to R_IDLE.
  - Latency: AR handshake at cycle N gives RVALID at N+1+RESP_DELAY.
- Read and write engines are fully independent and may overlap.
- Same-word collision: when a read is sampled in the same cycle as a write commit to the same word, the read returns the pre-write data.
- Decode:
  - offset = addr - BASE_ADDR, computed in ADDR_WIDTH bits with wrap.
  - If offset >= DEPTH*STRB_WIDTH, or addr < BASE_ADDR, the response is DECERR (2'b11).
  - Otherwise, if offset[log2(STRB_WIDTH)-1:0] != 0, the response is SLVERR (2'b10). Memory is not written and RDATA=0.
  - Otherwise the response is OKAY (2'b00) and the word index is offset >> log2(STRB_WIDTH).
  - Error precedence: DECERR over SLVERR.
- Strobes: byte i is written only when WSTRB[i]=1. WSTRB=0 gives an OKAY response with no change.
- EXOKAY is never returned.
- RDATA is 0 whenever RVALID=0.

Decomposition:
- Extend axi_lite_pkg with:
  - parameterised width localparams defaulting to the values above;
  - resp_t and the four RESP_* constants (already present);
  - new enums w_state_t {W_IDLE, W_COMMIT, W_DELAY, W_RESP} and r_state_t {R_IDLE, R_DELAY, R_RESP};
  - a decode-result typedef {resp_t resp; logic [$clog2(DEPTH)-1:0] idx}.
- One natural sub-module: axi_lite_addr_decode. It is combinational, takes addr and returns resp/idx, and is instantiated twice (AR and AW paths).
- Memory stays an inline array in the top.

Test Plan (DATA_WIDTH=32, DEPTH=16, BASE_ADDR=0x100, RESP_DELAY=0 unless stated):
- Write 0x11223344 to 0x108 with WSTRB=4'hF; read 0x108 -> BRESP=0, RDATA=0x11223344, RRESP=0, RVALID one cycle after AR handshake.
- Then write 0xAABBCCDD to 0x108 with WSTRB=4'b0101; read -> RDATA=0x11BB33DD.
- Read 0x140 and write 0x0FC -> RRESP=DECERR, RDATA=0, BRESP=DECERR; a re-read of 0x13C is unchanged. Read 0x10A -> RRESP=SLVERR.
- W handshake 3 cycles before AW, with BREADY held low 5 cycles -> BVALID stays 1 with BRESP stable, AWREADY/WREADY stay 0 until the B handshake, and both return to 1 the cycle after.
- RESP_DELAY=3: AR at cycle 10 -> RVALID rises at cycle 14. Simultaneous AR to 0x108 and write commit to 0x108 -> old data returned.
- ARESETN=0 for 1 cycle while RVALID=1 and the write FSM is in W_RESP -> RVALID=BVALID=0 next cycle, all READYs 1 the cycle after reset release, and a new read still returns the pre-reset memory contents.
